// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit: single-outstanding req/ack data bus, lane steering and load extension.
// Optional define LSU_MISALIGN_CHK_EN rejects misaligned half/word accesses without touching the bus.
module lsu_mem_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_err,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [31:0] cnt;

   logic        f3_ok;
   logic        misalign;
   logic        timeout_hit;
   logic [35:0] lanes;

   // Byte enables in [35:32], lane-replicated store data in [31:0].
   function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4'b0001 << off, {4{wd[7:0]}}};
         2'b01:   return {4'b0011 << {off[1], 1'b0}, {2{wd[15:0]}}};
         default: return {4'b1111, wd};
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
      logic        [7:0]  b;
      logic        [15:0] h;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h  = off[1] ? word[31:16] : word[15:0];
      sb = signed'(b);
      sh = signed'(h);
      case (f3)
         3'b000:  return 32'(sb);
         3'b001:  return 32'(sh);
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   always_comb begin
      if (i_we)
         f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
      else
         f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                 (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
`ifdef LSU_MISALIGN_CHK_EN
      misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      lanes       = store_lanes(i_funct3, i_addr[1:0], i_wdata);
      timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_IDLE;
         funct3_q    <= 3'd0;
         off_q       <= 2'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         cnt         <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_req) begin
                  funct3_q    <= i_funct3;
                  off_q       <= i_addr[1:0];
                  mem_we_q    <= i_we;
                  mem_addr_q  <= {i_addr[31:2], 2'b00};
                  mem_be_q    <= lanes[35:32];
                  mem_wdata_q <= lanes[31:0];
                  cnt         <= 32'd0;
                  // Rejected accesses complete straight away without a bus cycle.
                  if (!f3_ok || misalign) begin
                     state   <= S_DONE;
                     err_q   <= 1'b1;
                     rdata_q <= 32'd0;
                  end else begin
                     state   <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (i_mem_ack) begin
                  state   <= S_DONE;
                  err_q   <= i_mem_err;
                  rdata_q <= i_mem_err ? 32'd0 : load_extend(funct3_q, off_q, i_mem_rdata);
               end else if (timeout_hit) begin
                  state   <= S_DONE;
                  err_q   <= 1'b1;
                  rdata_q <= 32'd0;
               end else begin
                  cnt     <= cnt + 32'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_busy      = ((state == S_IDLE) && i_req) || (state == S_REQ);
   assign o_done      = (state == S_DONE);
   assign o_rdata     = rdata_q;
   assign o_err       = err_q;
   assign o_mem_req   = (state == S_REQ);
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_be    = mem_be_q;
   assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed vector table, hand sequences for reset/back-to-back,
// and randomized transactions checked against an arithmetic reference model.
module tb_lsu_mem_stage;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req = 1'b0;
   logic        i_we = 1'b0;
   logic [2:0]  i_funct3 = 3'd0;
   logic [31:0] i_addr = 32'd0;
   logic [31:0] i_wdata = 32'd0;
   logic        o_busy, o_done, o_err, o_mem_req, o_mem_we;
   logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_ack = 1'b0;
   logic [31:0] i_mem_rdata = 32'd0;
   logic        i_mem_err = 1'b0;

   always #5 clk = ~clk;

   lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
      .o_rdata(o_rdata), .o_err(o_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
      .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err)
   );

   typedef struct {
      bit          bus;
      bit          err;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          lat;
      int          reqc;
   } exp_t;

   typedef struct {
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          merr;
      int          delay;
      exp_t        e;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: expected outcome of one access from the architectural rules.
   function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] bus_rdata,
                                  input bit merr, input int delay);
      exp_t        e;
      int          off;
      int          sz;
      bit          ok;
      logic [31:0] v;
      e   = '{default: 0};
      off = int'(addr[1:0]);
      sz  = int'(f3[1:0]);
      ok  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_MISALIGN_CHK_EN
      if ((sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0)) ok = 1'b0;
`endif
      if (!ok) begin
         e.err = 1'b1;
         e.lat = 1;
         return e;
      end
      e.bus = 1'b1;
      case (sz)
         0: begin e.be = 4'(1 << off); e.wdata = 32'(wdata[7:0]) * 32'h01010101; end
         1: begin e.be = 4'(3 << ((off / 2) * 2)); e.wdata = 32'(wdata[15:0]) * 32'h00010001; end
         default: begin e.be = 4'hF; e.wdata = wdata; end
      endcase
      if (delay < 0 || delay >= TO) begin
         e.err  = 1'b1;
         e.lat  = TO + 1;
         e.reqc = TO;
      end else begin
         e.lat  = delay + 2;
         e.reqc = delay + 1;
         e.err  = merr;
         if (!merr) begin
            case (sz)
               0: begin
                  v = (bus_rdata >> (8 * off)) & 32'hFF;
                  if (!f3[2] && v >= 32'd128) v = v - 32'd256;
               end
               1: begin
                  v = (bus_rdata >> (16 * (off / 2))) & 32'hFFFF;
                  if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
               end
               default: v = bus_rdata;
            endcase
            e.rdata = v;
         end
      end
      return e;
   endfunction

   task automatic run_txn(input string tag, input vec_t t);
      int          lat, reqc;
      bit          got_done, stable_ok;
      logic [31:0] r, a, wd;
      logic [3:0]  be;
      logic        er, bz, w;
      lat = 0; reqc = 0; got_done = 0; stable_ok = 1;
      r = '0; a = '0; wd = '0; be = '0; er = 0; bz = 1; w = 0;
      i_req = 1'b1; i_we = t.we; i_funct3 = t.f3; i_addr = t.addr; i_wdata = t.wdata;
      i_mem_rdata = t.rdata; i_mem_err = t.merr; i_mem_ack = 1'b0;
      #1;
      chk({tag, "_busy_req"}, o_busy, 1'b1);
      while (!got_done && lat < 40) begin
         tick();
         lat++;
         if (o_done) begin
            got_done = 1; r = o_rdata; er = o_err; bz = o_busy;
         end else if (o_mem_req) begin
            reqc++;
            if (reqc == 1) begin
               a = o_mem_addr; be = o_mem_be; wd = o_mem_wdata; w = o_mem_we;
            end else if (a !== o_mem_addr || be !== o_mem_be || wd !== o_mem_wdata || w !== o_mem_we)
               stable_ok = 0;
            if (o_busy !== 1'b1) stable_ok = 0;
            i_mem_ack = ((reqc - 1) == t.delay);
         end else begin
            i_mem_ack = 1'b0;
         end
      end
      i_mem_ack = 1'b0;
      i_req = 1'b0;
      chk({tag, "_done"}, got_done, 1'b1);
      chk({tag, "_lat"}, lat, t.e.lat);
      chk({tag, "_err"}, er, t.e.err);
      chk({tag, "_busy_done"}, bz, 1'b0);
      chk({tag, "_reqc"}, reqc, t.e.reqc);
      if (!t.we || t.e.err) chk({tag, "_rdata"}, r, t.e.rdata);
      if (t.e.bus) begin
         chk({tag, "_addr"}, a, {t.addr[31:2], 2'b00});
         chk({tag, "_we"}, w, t.we);
         chk({tag, "_be"}, be, t.e.be);
         if (t.we) chk({tag, "_wdata"}, wd, t.e.wdata);
         chk({tag, "_stable"}, stable_ok, 1'b1);
      end
      tick();
   endtask

   vec_t tbl[14];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   cnt_done;

      tbl[0]  = '{1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, '{1, 0, 32'h0, 4'hF, 32'hDEADBEEF, 2, 1}};
      tbl[1]  = '{1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, '{1, 0, 32'h0, 4'h8, 32'hA5A5A5A5, 2, 1}};
      tbl[2]  = '{0, 3'b000, 32'h202, 32'h0, 32'h12F34567, 0, 1, '{1, 0, 32'hFFFFFFF3, 4'h4, 32'h0, 3, 2}};
      tbl[3]  = '{0, 3'b100, 32'h202, 32'h0, 32'h12F34567, 0, 0, '{1, 0, 32'h000000F3, 4'h4, 32'h0, 2, 1}};
      tbl[4]  = '{0, 3'b001, 32'h202, 32'h0, 32'h12F34567, 0, 2, '{1, 0, 32'h000012F3, 4'hC, 32'h0, 4, 3}};
      tbl[5]  = '{0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, -1, '{1, 1, 32'h0, 4'hF, 32'h0, 5, 4}};
      tbl[6]  = '{0, 3'b010, 32'h300, 32'h0, 32'h00000055, 1, 0, '{1, 1, 32'h0, 4'hF, 32'h0, 2, 1}};
      tbl[7]  = '{0, 3'b011, 32'h400, 32'h0, 32'h11111111, 0, 0, '{0, 1, 32'h0, 4'h0, 32'h0, 1, 0}};
`ifdef LSU_MISALIGN_CHK_EN
      tbl[8]  = '{0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, '{0, 1, 32'h0, 4'h0, 32'h0, 1, 0}};
`else
      tbl[8]  = '{0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, '{1, 0, 32'hCAFEF00D, 4'hF, 32'h0, 2, 1}};
`endif
      tbl[9]  = '{1, 3'b001, 32'h106, 32'h1234ABCD, 32'h0, 0, 0, '{1, 0, 32'h0, 4'hC, 32'hABCDABCD, 2, 1}};
      tbl[10] = '{0, 3'b001, 32'h200, 32'h0, 32'h00008001, 0, 0, '{1, 0, 32'hFFFF8001, 4'h3, 32'h0, 2, 1}};
      tbl[11] = '{0, 3'b101, 32'h200, 32'h0, 32'h00008001, 0, 0, '{1, 0, 32'h00008001, 4'h3, 32'h0, 2, 1}};
      tbl[12] = '{0, 3'b010, 32'h500, 32'h0, 32'h89ABCDEF, 0, 3, '{1, 0, 32'h89ABCDEF, 4'hF, 32'h0, 5, 4}};
      tbl[13] = '{1, 3'b100, 32'h600, 32'h77, 32'h0, 0, 0, '{0, 1, 32'h0, 4'h0, 32'h0, 1, 0}};

      // Reset state
      i_rst = 1'b1;
      tick(); tick();
      i_rst = 1'b0;
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_err", o_err, 1'b0);
      chk("rst_mem_req", o_mem_req, 1'b0);
      chk("rst_mem_we", o_mem_we, 1'b0);
      chk("rst_mem_addr", o_mem_addr, 32'h0);
      chk("rst_mem_be", o_mem_be, 4'h0);
      chk("rst_mem_wdata", o_mem_wdata, 32'h0);

      // Ack while idle is ignored
      i_mem_ack = 1'b1;
      tick(); tick();
      chk("idle_ack_done", o_done, 1'b0);
      chk("idle_ack_req", o_mem_req, 1'b0);
      chk("idle_ack_busy", o_busy, 1'b0);
      i_mem_ack = 1'b0;
      tick();

      for (int i = 0; i < 14; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

      // Back-to-back: request held through DONE is taken in the following IDLE cycle
      i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h700; i_mem_rdata = 32'h11223344;
      i_mem_err = 1'b0;
      tick();
      chk("b2b_req1", o_mem_req, 1'b1);
      i_mem_ack = 1'b1;
      tick();
      chk("b2b_done1", o_done, 1'b1);
      chk("b2b_rdata1", o_rdata, 32'h11223344);
      chk("b2b_busy_done", o_busy, 1'b0);
      i_mem_ack = 1'b0; i_addr = 32'h704; i_mem_rdata = 32'h55667788;
      tick();
      chk("b2b_idle_req", o_mem_req, 1'b0);
      chk("b2b_idle_busy", o_busy, 1'b1);
      tick();
      chk("b2b_req2", o_mem_req, 1'b1);
      chk("b2b_addr2", o_mem_addr, 32'h704);
      i_mem_ack = 1'b1;
      tick();
      chk("b2b_done2", o_done, 1'b1);
      chk("b2b_rdata2", o_rdata, 32'h55667788);
      i_mem_ack = 1'b0; i_req = 1'b0;
      tick();

      // Reset while a request is outstanding
      i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h800; i_wdata = 32'h0BADF00D;
      tick();
      chk("mid_rst_req", o_mem_req, 1'b1);
      i_rst = 1'b1; i_req = 1'b0;
      tick();
      i_rst = 1'b0;
      chk("mid_rst_mem_req", o_mem_req, 1'b0);
      chk("mid_rst_done", o_done, 1'b0);
      chk("mid_rst_busy", o_busy, 1'b0);
      chk("mid_rst_mem_we", o_mem_we, 1'b0);
      chk("mid_rst_mem_addr", o_mem_addr, 32'h0);
      chk("mid_rst_mem_be", o_mem_be, 4'h0);
      chk("mid_rst_mem_wdata", o_mem_wdata, 32'h0);
      chk("mid_rst_rdata", o_rdata, 32'h0);
      chk("mid_rst_err", o_err, 1'b0);
      cnt_done = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (o_done) cnt_done++;
      end
      chk("mid_rst_no_done", cnt_done, 0);

      // Randomized transactions against the reference model
      for (int i = 0; i < 150; i++) begin
         int r;
         v.we    = 1'($urandom_range(0, 1));
         v.f3    = 3'($urandom_range(0, 7));
         v.addr  = $urandom;
         v.wdata = $urandom;
         v.rdata = $urandom;
         v.merr  = ($urandom_range(0, 7) == 0);
         r       = int'($urandom_range(0, 6));
         v.delay = (r == 6) ? -1 : r;
         v.e     = model(v.we, v.f3, v.addr, v.wdata, v.rdata, v.merr, v.delay);
         run_txn($sformatf("rnd%0d", i), v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit sitting directly downstream of the ALU in the RV32I core: consumes the ALU result as the effective address and the rs2 value as store data. Drives a single-outstanding request/acknowledge data-memory bus and returns sign- or zero-extended load data to writeback. Stalls the core while a memory access is in flight.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles in REQ waiting for ack; 0 disables the timeout.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_req  in  1  core requests a load/store; held with operands stable until o_done.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- i_addr  in  32  effective address (ALU result).
- i_wdata  in  32  store data (rs2).
- o_busy  out  1  stall to core.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load data; valid when o_done.
- o_err  out  1  access failed; valid when o_done.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  bus write.
- o_mem_addr  out  32  word address, {i_addr[31:2], 2'b00}.
- o_mem_be  out  4  byte enables.
- o_mem_wdata  out  32  lane-replicated store data.
- i_mem_ack  in  1  bus accepts/completes the request.
- i_mem_rdata  in  32  read word; valid with i_mem_ack.
- i_mem_err  in  1  bus error; valid with i_mem_ack.

## Operation
- FSM states: IDLE, REQ, DONE. Reset -> IDLE.
- IDLE: on i_req, register we/funct3/addr/wdata. Invalid funct3 (loads 011/110/111; stores other than 000/001/010) -> DONE with error, no bus access. Otherwise -> REQ.
- REQ: o_mem_req=1; o_mem_we/addr/be/wdata held stable from registered copies. i_mem_ack=1 -> capture rdata and err, go DONE. Timeout counter increments each REQ cycle; reaching TIMEOUT_CYCLES without ack -> DONE with o_err=1, o_mem_req deasserted.
- DONE: o_done=1 for one cycle, then IDLE.
- Byte lane off = addr[1:0]. Byte: be = 4'b0001<<off, wdata = {4{wdata[7:0]}}. Half: be = 4'b0011<<{off[1],1'b0}, wdata = {2{wdata[15:0]}}. Word: be = 4'b1111.
- Loads: select byte/half from captured word by off; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. o_mem_be reflects accessed lanes on loads too.
- o_err=1 forces o_rdata=0.
- o_busy = (state==IDLE & i_req) | (state==REQ); low in DONE so the core advances that cycle.

## Timing
- Reset values: o_busy 0, o_done 0, o_rdata 0, o_err 0, o_mem_req 0, o_mem_we 0, o_mem_addr 0, o_mem_be 0, o_mem_wdata 0.
- Best-case latency: i_req in cycle 0, o_mem_req cycle 1, ack in cycle 1, o_done cycle 2.
- Ack is accepted in any REQ cycle including the first; ack outside REQ is ignored.
- Ack and timeout in the same cycle: ack wins.
- i_req in DONE is ignored; a back-to-back request is accepted in the following IDLE cycle.
- Reset mid-operation: o_mem_req drops the cycle after i_rst sampled high; no o_done issued; bus must tolerate an abandoned request.

## Configuration
- LSU_MISALIGN_CHK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, go IDLE -> DONE with o_err=1, o_rdata=0, no bus request (latency 1 cycle).
- Undefined: no check; half accesses use off[1] only, word accesses ignore off; normal bus access.

## Test plan
- SW addr 0x100 wdata 0xDEADBEEF, ack in first REQ cycle -> o_mem_addr 0x100, be 4'b1111, wdata 0xDEADBEEF, o_done 2 cycles after i_req, o_err 0.
- SB addr 0x103 wdata 0x000000A5 -> be 4'b1000, o_mem_wdata 0xA5A5A5A5.
- LB addr 0x202 / LBU addr 0x202, i_mem_rdata 0x12F34567 -> o_rdata 0xFFFFFFF3 / 0x000000F3; LH addr 0x202 -> 0x000012F3.
- LW with ack withheld, TIMEOUT_CYCLES=4 -> o_mem_req high 4 cycles then drops, o_done with o_err 1, o_rdata 0; ack with i_mem_err=1 -> o_err 1.
- LW addr 0x101: macro on -> o_done next cycle, o_err 1, no o_mem_req; macro off -> bus access at 0x100, o_rdata = i_mem_rdata.
- i_rst asserted during REQ -> all outputs 0 next cycle, no o_done; funct3 011 load -> o_err 1, no bus request.
